timer_ctrl: RTL and testbench

Control sequencer that sits directly upstream of the timer's load/increment count register. Turns start/stop/load button levels into that register's `select`, `ld_inc` and `in` drive. A prescaler paces increments at one per `PRESCALE` clocks. Load sequencing is arranged so the register's registered mode is always settled before any write strobe.

---
 rtl/timer_pkg.sv | 16 +
 rtl/edge_det.sv | 20 ++
 rtl/timer_ctrl.sv | 127 ++++++++++++
 tb/tb_timer_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the timer count register and its control sequencer.
// Latency: n/a (types and defaults only). Backpressure: n/a.
package timer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LD_SEL = 3'd1,
      ST_LD_WR  = 3'd2,
      ST_RUN    = 3'd3,
      ST_PAUSE  = 3'd4
   } timer_state_t;

   localparam int WIDTH_DEF    = 8;
   localparam int PRESCALE_DEF = 50;

endpackage

// File: rtl/edge_det.sv
// Rising-edge detector for a pre-synchronised button level.
// Latency: edge is combinational on the level, one register of history.
// Backpressure: none; prev resets high so a level held through reset gives no edge.
module edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic level,
   output logic rise
);

   logic prev;

   always_ff @(posedge clk) begin
      if (!rst_n) prev <= 1'b1;
      else        prev <= level;
   end

   assign rise = level & ~prev;

endmodule

// File: rtl/timer_ctrl.sv
// Control sequencer driving the timer count register; TIMER_CTRL_LIMIT_EN adds the terminal-count halt.
// Latency: outputs registered; load strobe 2 cycles after the load edge, first run strobe PRESCALE cycles after start.
// Backpressure: none; edges arriving while a load is being sequenced are dropped.
module timer_ctrl
   import timer_pkg::*;
#(
   parameter int WIDTH    = WIDTH_DEF,
   parameter int PRESCALE = PRESCALE_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] cnt,
   input  logic [WIDTH-1:0] limit,
   output logic             select,
   output logic             ld_inc,
   output logic [WIDTH-1:0] in,
   output logic             running,
   output logic             done
);

   localparam int            PW       = $clog2(PRESCALE);
   localparam logic [PW-1:0] PSC_LAST = PW'(PRESCALE - 1);

   timer_state_t     state;
   logic [PW-1:0]    psc;
   logic [PW-1:0]    psc_nxt;
   logic [WIDTH-1:0] data;
   logic             start_e;
   logic             stop_e;
   logic             load_e;
   logic             at_limit;

   edge_det u_start_ed (.clk(clk), .rst_n(rst_n), .level(start), .rise(start_e));
   edge_det u_stop_ed  (.clk(clk), .rst_n(rst_n), .level(stop),  .rise(stop_e));
   edge_det u_load_ed  (.clk(clk), .rst_n(rst_n), .level(load),  .rise(load_e));

`ifdef TIMER_CTRL_LIMIT_EN
   assign at_limit = (cnt == limit);
`else
   logic limit_unused;
   assign limit_unused = ^{cnt, limit};
   assign at_limit     = 1'b0;
`endif

   assign psc_nxt = (psc == PSC_LAST) ? '0 : psc + PW'(1);
   assign in      = data;

   // Strobes are computed one cycle ahead so every output is a flop; cnt only
   // moves on our own strobes, so its value now is its value in the strobe cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         psc     <= '0;
         data    <= '0;
         select  <= 1'b0;
         ld_inc  <= 1'b0;
         running <= 1'b0;
         done    <= 1'b0;
      end else begin
         ld_inc <= 1'b0;
         done   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (!stop_e && load_e) begin
                  state  <= ST_LD_SEL;
                  data   <= load_val;
                  select <= 1'b0;
               end else if (!stop_e && start_e) begin
                  state   <= ST_RUN;
                  psc     <= '0;
                  select  <= 1'b1;
                  running <= 1'b1;
               end
            end
            ST_LD_SEL: begin
               state  <= ST_LD_WR;
               ld_inc <= 1'b1;
            end
            ST_LD_WR: begin
               state <= ST_IDLE;
            end
            ST_RUN: begin
               if (at_limit) begin
                  state   <= ST_IDLE;
                  psc     <= '0;
                  select  <= 1'b0;
                  running <= 1'b0;
                  done    <= 1'b1;
               end else if (stop_e) begin
                  state   <= ST_PAUSE;
                  running <= 1'b0;
               end else begin
                  psc    <= psc_nxt;
                  ld_inc <= (psc_nxt == PSC_LAST);
               end
            end
            ST_PAUSE: begin
               if (stop_e) begin
                  state  <= ST_IDLE;
                  psc    <= '0;
                  select <= 1'b0;
               end else if (load_e) begin
                  state  <= ST_LD_SEL;
                  psc    <= '0;
                  data   <= load_val;
                  select <= 1'b0;
               end else if (start_e) begin
                  state   <= ST_RUN;
                  running <= 1'b1;
                  ld_inc  <= (psc == PSC_LAST) && !at_limit;
               end
            end
            default: begin
               state   <= ST_IDLE;
               psc     <= '0;
               select  <= 1'b0;
               running <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl paired with a behavioural count register; strobe times predicted arithmetically.
module tb_timer_ctrl;

   localparam int W = 8;
   localparam int P = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start, stop, load;
   logic [W-1:0] load_val, cnt, limit, in_w;
   logic         select, ld_inc, running, done;

   always #5 clk = ~clk;

   timer_ctrl #(.WIDTH(W), .PRESCALE(P)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .load(load),
      .load_val(load_val), .cnt(cnt), .limit(limit), .select(select),
      .ld_inc(ld_inc), .in(in_w), .running(running), .done(done)
   );

   // Count register driven by the controller.
   always @(posedge clk) begin
      if (!rst_n)      cnt <= '0;
      else if (ld_inc) cnt <= select ? cnt + 8'd1 : in_w;
   end

   int checks = 0;
   int errors = 0;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: run/pause flags plus the cycle numbers of expected strobes.
   int cyc         = 0;
   bit m_run       = 0;
   bit m_pause     = 0;
   int run_entry   = 0;
   int next_strobe = -1;
   int held_phase  = 0;
   int ld_strobe   = -1;
   int ld_val      = 0;
   int exp_cnt     = 0;
   int done_at     = -1;

   function automatic int phase_now();
      return ((P - 1 - (next_strobe - cyc)) % P + P) % P;
   endfunction

   task automatic model_reset();
      m_run = 0; m_pause = 0; next_strobe = -1; ld_strobe = -1;
      exp_cnt = 0; done_at = -1;
   endtask

   task automatic step(input string tag);
      bit exp_strobe;
      @(posedge clk); #1; cyc++;
      exp_strobe = 0;
      chk_eq({tag, ":cnt"}, 32'(cnt), 32'(exp_cnt));
      chk_eq({tag, ":done"}, 32'(done), 32'(cyc == done_at));
`ifdef TIMER_CTRL_LIMIT_EN
      if (m_run && cyc >= run_entry && exp_cnt == int'(limit)) begin
         m_run   = 0;
         done_at = cyc + 1;
      end
`endif
      if (m_run && cyc == next_strobe) begin
         exp_strobe  = 1;
         exp_cnt     = (exp_cnt + 1) % 256;
         next_strobe = next_strobe + P;
      end
      if (cyc == ld_strobe) begin
         exp_strobe = 1;
         exp_cnt    = ld_val;
         chk_eq({tag, ":ld_in"}, 32'(in_w), 32'(ld_val));
         chk_eq({tag, ":ld_sel"}, 32'(select), 32'd0);
      end
      chk_eq({tag, ":ld_inc"}, 32'(ld_inc), 32'(exp_strobe));
   endtask

   function automatic bit model_idle();
      return !m_run && !m_pause && cyc > ld_strobe;
   endfunction

   task automatic press_start();
      start = 1'b1;
      if (m_pause) begin
         m_pause = 0; m_run = 1; run_entry = cyc + 1;
         next_strobe = cyc + (P - held_phase);
      end else if (model_idle()) begin
         m_run = 1; run_entry = cyc + 1; next_strobe = cyc + P;
      end
      step("start");
      start = 1'b0;
   endtask

   task automatic press_stop(input bit with_load);
      stop = 1'b1;
      load = with_load;
      if (m_run && cyc >= run_entry) begin
         held_phase = phase_now();
         m_run = 0; m_pause = 1;
      end else if (m_pause) begin
         m_pause = 0;
      end
      step("stop");
      stop = 1'b0;
      load = 1'b0;
   endtask

   task automatic press_load(input logic [W-1:0] v);
      load_val = v;
      load     = 1'b1;
      if (m_pause || model_idle()) begin
         m_pause = 0; ld_strobe = cyc + 2; ld_val = int'(v);
      end
      step("load");
      load = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, s, npulse;
      logic [W-1:0] v;
      rst_n = 1'b0; start = 1'b1; stop = 1'b0; load = 1'b0;
      load_val = '0; limit = 8'hFF;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Reset values, then start held high must not start the timer.
      chk_eq("rst_select", 32'(select), 32'd0);
      chk_eq("rst_ld_inc", 32'(ld_inc), 32'd0);
      chk_eq("rst_in", 32'(in_w), 32'd0);
      chk_eq("rst_running", 32'(running), 32'd0);
      chk_eq("rst_done", 32'(done), 32'd0);
      for (int i = 0; i < 5; i++) begin
         step("held");
         chk_eq("held_running", 32'(running), 32'd0);
      end
      start = 1'b0;
      step("rel"); step("rel");

      // Load 0x2A from IDLE.
      press_load(8'h2A);
      chk_eq("ld_sel_k1", 32'(select), 32'd0);
      step("ld"); step("ld");
      chk_eq("ld_cnt_k3", 32'(cnt), 32'h2A);
      chk_eq("ld_idle_running", 32'(running), 32'd0);

      // Run: strobes at k+4, k+8.
      k = cyc;
      press_start();
      while (cyc < k + 9) begin
         chk_eq("run_running", 32'(running), 32'd1);
         chk_eq("run_select", 32'(select), 32'd1);
         step("run");
      end
      chk_eq("run_cnt_2c", 32'(cnt), 32'h2C);

      // Pause at prescaler 2, resume, first strobe 2 cycles after the start edge.
      for (int i = 0; i < P && phase_now() != 2; i++) step("topsc2");
      press_stop(1'b0);
      repeat (6) step("paused");
      chk_eq("pause_running", 32'(running), 32'd0);
      chk_eq("pause_select", 32'(select), 32'd1);
      s = cyc;
      press_start();
      chk_eq("resume_running", 32'(running), 32'd1);
      step("resume");
      chk_eq("resume_strobe_s2", 32'(ld_inc), 32'd1);
      repeat (5) step("resume");

      // Stop and load together: stop wins, count unchanged.
      v = cnt;
      press_stop(1'b1);
      repeat (4) step("stopld");
      chk_eq("stopld_select", 32'(select), 32'd1);
      chk_eq("stopld_cnt", 32'(cnt), 32'(v));

      // Load from PAUSE: select drops a cycle before the strobe.
      v = 8'($urandom_range(0, 200));
      press_load(v);
      chk_eq("pld_sel", 32'(select), 32'd0);
      chk_eq("pld_noinc", 32'(ld_inc), 32'd0);
      step("pld"); step("pld");
      chk_eq("pld_cnt", 32'(cnt), 32'(v));
      chk_eq("pld_idle_select", 32'(select), 32'd0);
      chk_eq("pld_idle_running", 32'(running), 32'd0);

      // Terminal count.
      limit = 8'h05;
      press_load(8'h03);
      step("lim"); step("lim");
      npulse = 0;
      press_start();
      for (int i = 0; i < 14; i++) begin
         step("lim");
         if (done === 1'b1) npulse++;
      end
`ifdef TIMER_CTRL_LIMIT_EN
      chk_eq("lim_cnt", 32'(cnt), 32'h05);
      chk_eq("lim_pulses", 32'(npulse), 32'd1);
      chk_eq("lim_running", 32'(running), 32'd0);
`else
      chk_eq("lim_cnt", 32'(cnt), 32'h06);
      chk_eq("lim_pulses", 32'(npulse), 32'd0);
      chk_eq("lim_running", 32'(running), 32'd1);
`endif
      press_stop(1'b0);
      step("halt");
      press_stop(1'b0);
      step("halt");
      limit = 8'hFF;

      // Reset while in LD_SEL aborts the load.
      press_load(8'h77);
      rst_n = 1'b0;
      model_reset();
      step("rstld");
      rst_n = 1'b1;
      chk_eq("rstld_select", 32'(select), 32'd0);
      chk_eq("rstld_in", 32'(in_w), 32'd0);
      chk_eq("rstld_running", 32'(running), 32'd0);
      step("rstld");

      // Randomised load / run / pause / resume / halt cycles.
      for (int it = 0; it < 6; it++) begin
         press_load(8'($urandom_range(0, 200)));
         repeat (3) step("rnd");
         press_start();
         repeat ($urandom_range(3, 15)) step("rnd");
         press_stop(1'b0);
         repeat ($urandom_range(2, 6)) step("rnd");
         press_start();
         repeat ($urandom_range(3, 12)) step("rnd");
         press_stop(1'b0);
         step("rnd");
         press_stop(1'b0);
         repeat (3) step("rnd");
         chk_eq("rnd_idle_select", 32'(select), 32'd0);
         chk_eq("rnd_idle_running", 32'(running), 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
